// File: rtl/mc_alu_if.sv
// ---------------------------------------------------------------------------
// mc_alu_if
// Bundles the control-unit side of the multi-cycle ALU: request (start,
// control, A, B) and response (C0, C1, zero, busy, done, div0).
//   master : control unit / testbench (drives start, control, A, B)
//   slave  : mc_alu (drives C0, C1, zero, busy, done, div0)
// WIDTH must match the WIDTH of the attached mc_alu.
// ---------------------------------------------------------------------------
interface mc_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C0;
    logic [WIDTH-1:0] C1;
    logic             zero;
    logic             busy;
    logic             done;
    logic             div0;

    modport master (
        output start, control, A, B,
        input  C0, C1, zero, busy, done, div0
    );

    modport slave (
        input  start, control, A, B,
        output C0, C1, zero, busy, done, div0
    );
endinterface

// File: rtl/mc_alu.sv
// ---------------------------------------------------------------------------
// mc_alu
// Multi-cycle ALU. Single-cycle ops (add, sub, and, or, ror, rol, shr, shra,
// shl, neg, not) complete on the accepting edge. Multiply (shift-add) and
// divide (restoring) iterate one bit per clock for WIDTH edges, producing a
// 2*WIDTH product on {C1,C0} or quotient/remainder on C0/C1.
// Ports:
//   clk   rising-edge clock
//   rstn  synchronous active-low reset
//   bus   mc_alu_if.slave: start/control/A/B in, C0/C1/zero/busy/done/div0 out
// Build option:
//   MC_ALU_SIGNED_EN  when defined, mul/div operate on two's complement
//                     operands (magnitudes iterated, signs fixed at the end).
// ---------------------------------------------------------------------------
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rstn,
    mc_alu_if.slave bus
);

`ifdef MC_ALU_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;

    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic             is_div, neg_q, neg_r, div_by0;
    logic [WIDTH-1:0] c0, c1;
    logic             zero, done, div0;

    logic                    accept, multi, sa, sb;
    logic [SHW-1:0]          shamt;
    logic signed [WIDTH-1:0] a_s;
    logic [WIDTH-1:0]        sc_res;
    logic [WIDTH:0]          msum, shifted;
    logic [WIDTH-1:0]        mhi, mlo, dhi, dlo, diff;
    logic                    ge;
    logic [2*WIDTH-1:0]      prod;
    logic [WIDTH-1:0]        res0, res1;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? ('0 - v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? ('0 - v) : v;
    endfunction

    assign accept = bus.start && (state == IDLE);
    assign multi  = (bus.control == 4'd9) || (bus.control == 4'd10);
    assign sa     = SIGNED_EN & bus.A[WIDTH-1];
    assign sb     = SIGNED_EN & bus.B[WIDTH-1];
    assign shamt  = bus.B[SHW-1:0];
    assign a_s    = bus.A;

    always_comb begin
        sc_res = '0;
        case (bus.control)
            4'd0:    sc_res = bus.A + bus.B;
            4'd1:    sc_res = bus.A + ~bus.B + ONE;
            4'd2:    sc_res = bus.A & bus.B;
            4'd3:    sc_res = bus.A | bus.B;
            4'd4:    sc_res = (bus.A >> shamt) | (bus.A << (WIDTH - int'(shamt)));
            4'd5:    sc_res = (bus.A << shamt) | (bus.A >> (WIDTH - int'(shamt)));
            4'd6:    sc_res = bus.A >> shamt;
            4'd7:    sc_res = a_s >>> shamt;
            4'd8:    sc_res = bus.A << shamt;
            4'd11:   sc_res = '0 - bus.A;
            4'd12:   sc_res = ~bus.A;
            default: sc_res = '0;
        endcase
    end

    // Iteration step: multiply shifts {carry,hi,lo} right after a conditional
    // add; divide shifts the next dividend bit into the partial remainder and
    // subtracts the divisor when it fits. A zero divisor always "fits", which
    // naturally yields quotient all-ones and remainder equal to the dividend.
    always_comb begin
        msum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        mhi     = msum[WIDTH:1];
        mlo     = {msum[0], lo[WIDTH-1:1]};
        shifted = {hi, lo[WIDTH-1]};
        ge      = shifted >= {1'b0, opnd};
        diff    = shifted[WIDTH-1:0] - opnd;
        dhi     = ge ? diff : shifted[WIDTH-1:0];
        dlo     = {lo[WIDTH-2:0], ge};
    end

    // Final-edge results with sign correction applied in the same edge.
    always_comb begin
        prod = cond_neg2({mhi, mlo}, neg_q);
        res0 = prod[WIDTH-1:0];
        res1 = prod[2*WIDTH-1:WIDTH];
        if (is_div) begin
            res0 = div_by0 ? '1 : cond_neg(dlo, neg_q);
            res1 = cond_neg(dhi, neg_r);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && multi) state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Control and architectural outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt  <= '0;
            c0   <= '0;
            c1   <= '0;
            zero <= 1'b0;
            done <= 1'b0;
            div0 <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                div0 <= 1'b0;
                cnt  <= SHW'(WIDTH - 1);
                if (!multi) begin
                    c0   <= sc_res;
                    c1   <= '0;
                    zero <= (sc_res == '0);
                    done <= 1'b1;
                end
            end
            if (state == RUN) begin
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    c0   <= res0;
                    c1   <= res1;
                    zero <= (res0 == '0);
                    done <= 1'b1;
                    div0 <= is_div & div_by0;
                end
            end
        end
    end

    // Iteration datapath: loaded with operand magnitudes at accept
    always_ff @(posedge clk) begin
        if (accept && multi) begin
            is_div  <= (bus.control == 4'd9);
            div_by0 <= (bus.B == '0);
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            hi      <= '0;
            if (bus.control == 4'd9) begin
                lo   <= cond_neg(bus.A, sa);
                opnd <= cond_neg(bus.B, sb);
            end else begin
                lo   <= cond_neg(bus.B, sb);
                opnd <= cond_neg(bus.A, sa);
            end
        end else if (state == RUN) begin
            hi <= is_div ? dhi : mhi;
            lo <= is_div ? dlo : mlo;
        end
    end

    assign bus.C0   = c0;
    assign bus.C1   = c1;
    assign bus.zero = zero;
    assign bus.busy = (state == RUN);
    assign bus.done = done;
    assign bus.div0 = div0;

endmodule
